counter_ng: RTL and testbench



---
 rtl/counter_pkg.sv | 23 ++
 rtl/counter_ng_next.sv | 39 +++
 rtl/counter_ng_t.sv | 68 ++++++
 rtl/counter_ng.sv | 82 ++++++++
 tb/tb_counter_ng.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared types and parameter checking for the counter_ng family.
// Optional sticky overflow flag is enabled by defining COUNTER_STICKY_OVF_EN.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } mode_t;

  localparam int unsigned MinWidth = 2;
  localparam int unsigned MaxWidth = 32;

  // Bounds are checked in 64 bits so Max == 2**Width-1 is representable at Width = 32.
  function automatic bit params_ok(input int unsigned width,
                                   input longint unsigned init,
                                   input longint unsigned min,
                                   input longint unsigned max);
    return (width >= MinWidth) && (width <= MaxWidth) &&
           (min < max) && (min <= init) && (init <= max) &&
           (max < (64'd1 << width));
  endfunction

endpackage

// File: rtl/counter_ng_next.sv
// Combinational next-step value and boundary detection for counter_ng.
module counter_ng_next
  import counter_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] value,
  input  logic             up,
  input  logic [Width-1:0] min,
  input  logic [Width-1:0] max,
  input  mode_t            mode,
  output logic [Width-1:0] next,
  output logic             hit
);

  logic [Width:0]   inc;
  logic [Width-1:0] dec;
  logic             at_max;
  logic             at_min;

  // The increment carries an extra bit so the compare against max cannot alias at 2**Width-1.
  assign inc    = {1'b0, value} + (Width+1)'(1);
  assign dec    = value - Width'(1);
  assign at_max = (inc > {1'b0, max});
  assign at_min = (value <= min);
  assign hit    = up ? at_max : at_min;

  always_comb begin
    next = value;
    if (up) begin
      if (at_max) next = (mode == CNT_WRAP) ? min : max;
      else        next = inc[Width-1:0];
    end else begin
      if (at_min) next = (mode == CNT_WRAP) ? max : min;
      else        next = dec;
    end
  end

endmodule

// File: rtl/counter_ng_t.sv
// Formal harness for counter_ng; compiled only when FORMAL is defined.
// Overflow properties follow COUNTER_STICKY_OVF_EN.
`ifdef FORMAL
module counter_ng_t
  import counter_pkg::*;
#(
  parameter int unsigned     Width = 32,
  parameter longint unsigned Init  = 8,
  parameter longint unsigned Min   = 8,
  parameter longint unsigned Max   = 64,
  parameter mode_t           Mode  = CNT_WRAP
) (
  input logic             Clk_i,
  input logic             Reset_i,
  input logic             En_i,
  input logic             Up_i,
  input logic             Load_i,
  input logic [Width-1:0] Data_i,
  input logic             Clear_i
);

  localparam logic [Width-1:0] MinV = Width'(Min);
  localparam logic [Width-1:0] MaxV = Width'(Max);

  logic [Width-1:0] data_q;
  logic             tc;
  logic             ovf;
  logic             init_done = 1'b0;

  counter_ng #(.Width(Width), .Init(Init), .Min(Min), .Max(Max), .Mode(Mode)) dut (
    .Clk_i      (Clk_i),
    .Reset_i    (Reset_i),
    .En_i       (En_i),
    .Up_i       (Up_i),
    .Load_i     (Load_i),
    .Data_i     (Data_i),
    .Data_o     (data_q),
    .Tc_o       (tc),
    .Overflow_o (ovf),
    .Clear_i    (Clear_i)
  );

  always_ff @(posedge Clk_i) init_done <= 1'b1;

  always_comb begin
    if (!init_done) assume (Reset_i);
  end

  a_range: assert property (@(posedge Clk_i) init_done |-> (data_q >= MinV && data_q <= MaxV));

  a_up: assert property (@(posedge Clk_i)
    (init_done && !Reset_i && !Load_i && En_i && Up_i && data_q != MaxV)
    |=> data_q == $past(data_q) + Width'(1));

  a_down: assert property (@(posedge Clk_i)
    (init_done && !Reset_i && !Load_i && En_i && !Up_i && data_q != MinV)
    |=> data_q == $past(data_q) - Width'(1));

  a_tc_bound: assert property (@(posedge Clk_i) tc |-> (data_q == MaxV || data_q == MinV));

`ifdef COUNTER_STICKY_OVF_EN
  a_ovf_set: assert property (@(posedge Clk_i) (tc && !Reset_i) |=> ovf);
`else
  a_ovf_zero: assert property (@(posedge Clk_i) !ovf);
`endif

endmodule
`endif

// File: rtl/counter_ng.sv
// Up/down counter between programmable bounds with load, wrap/saturate and terminal count.
// Sticky Overflow_o flag is built only when COUNTER_STICKY_OVF_EN is defined.
module counter_ng
  import counter_pkg::*;
#(
  parameter int unsigned     Width = 32,
  parameter longint unsigned Init  = 8,
  parameter longint unsigned Min   = 8,
  parameter longint unsigned Max   = 64,
  parameter mode_t           Mode  = CNT_WRAP
) (
  input  logic             Clk_i,
  input  logic             Reset_i,
  input  logic             En_i,
  input  logic             Up_i,
  input  logic             Load_i,
  input  logic [Width-1:0] Data_i,
  output logic [Width-1:0] Data_o,
  output logic             Tc_o,
  output logic             Overflow_o,
  input  logic             Clear_i
);

  if (!params_ok(Width, Init, Min, Max)) begin : g_bad_params
    $error("counter_ng: illegal Width/Init/Min/Max combination");
  end

  localparam logic [Width-1:0] InitV = Width'(Init);
  localparam logic [Width-1:0] MinV  = Width'(Min);
  localparam logic [Width-1:0] MaxV  = Width'(Max);
  localparam logic [Width:0]   MinX  = {1'b0, MinV};
  localparam logic [Width:0]   MaxX  = {1'b0, MaxV};

  logic [Width-1:0] count_q;
  logic [Width-1:0] step_next;
  logic [Width-1:0] load_val;
  logic             hit;

  counter_ng_next #(.Width(Width)) u_next (
    .value (count_q),
    .up    (Up_i),
    .min   (MinV),
    .max   (MaxV),
    .mode  (Mode),
    .next  (step_next),
    .hit   (hit)
  );

  // Load value is clamped into range so the count can never leave [Min, Max].
  always_comb begin
    load_val = Data_i;
    if ({1'b0, Data_i} < MinX)      load_val = MinV;
    else if ({1'b0, Data_i} > MaxX) load_val = MaxV;
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i)     count_q <= InitV;
    else if (Load_i) count_q <= load_val;
    else if (En_i)   count_q <= step_next;
  end

  assign Data_o = count_q;
  assign Tc_o   = En_i && !Load_i && !Reset_i && hit;

`ifdef COUNTER_STICKY_OVF_EN
  logic ovf_q;

  // Setting takes priority over clearing so a boundary event is never lost.
  always_ff @(posedge Clk_i) begin
    if (Reset_i)      ovf_q <= 1'b0;
    else if (Tc_o)    ovf_q <= 1'b1;
    else if (Clear_i) ovf_q <= 1'b0;
  end

  assign Overflow_o = ovf_q;
`else
  logic unused_clear;
  assign unused_clear = Clear_i;
  assign Overflow_o   = 1'b0;
`endif

endmodule

// File: tb/tb_counter_ng.sv
// Directed self-checking bench for counter_ng: wrap, saturate and narrow full-range instances.
// Expected Overflow_o values follow COUNTER_STICKY_OVF_EN.
module tb_counter_ng;
  import counter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  logic        w_en = 0, w_up = 0, w_load = 0, w_clear = 0;
  logic [31:0] w_din = 0;
  logic [31:0] w_q;
  logic        w_tc, w_ovf;

  logic        s_en = 0, s_up = 0, s_load = 0, s_clear = 0;
  logic [31:0] s_din = 0;
  logic [31:0] s_q;
  logic        s_tc, s_ovf;

  logic        n_en = 0, n_up = 0, n_load = 0, n_clear = 0;
  logic [3:0]  n_din = 0;
  logic [3:0]  n_q;
  logic        n_tc, n_ovf;

  int vectors = 0;
  int miscompares = 0;

`ifdef COUNTER_STICKY_OVF_EN
  localparam logic [31:0] Sticky = 32'd1;
`else
  localparam logic [31:0] Sticky = 32'd0;
`endif

  counter_ng #(.Width(32), .Init(8), .Min(8), .Max(64), .Mode(CNT_WRAP)) u_wrap (
    .Clk_i(clk), .Reset_i(reset), .En_i(w_en), .Up_i(w_up), .Load_i(w_load),
    .Data_i(w_din), .Data_o(w_q), .Tc_o(w_tc), .Overflow_o(w_ovf), .Clear_i(w_clear)
  );

  counter_ng #(.Width(32), .Init(8), .Min(8), .Max(64), .Mode(CNT_SAT)) u_sat (
    .Clk_i(clk), .Reset_i(reset), .En_i(s_en), .Up_i(s_up), .Load_i(s_load),
    .Data_i(s_din), .Data_o(s_q), .Tc_o(s_tc), .Overflow_o(s_ovf), .Clear_i(s_clear)
  );

  // Max equals 2**Width-1 here, exercising the widened boundary compare.
  counter_ng #(.Width(4), .Init(1), .Min(1), .Max(15), .Mode(CNT_WRAP)) u_narrow (
    .Clk_i(clk), .Reset_i(reset), .En_i(n_en), .Up_i(n_up), .Load_i(n_load),
    .Data_i(n_din), .Data_o(n_q), .Tc_o(n_tc), .Overflow_o(n_ovf), .Clear_i(n_clear)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    tick();
    check("rst_w_q", w_q, 32'd8);
    check("rst_s_q", s_q, 32'd8);
    check("rst_n_q", 32'(n_q), 32'd1);
    check("rst_w_ovf", 32'(w_ovf), 32'd0);
    check("rst_s_ovf", 32'(s_ovf), 32'd0);
    check("rst_n_ovf", 32'(n_ovf), 32'd0);

    // Plain up-count from Init
    reset = 1'b0; w_en = 1'b1; w_up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1; check("p1_tc", 32'(w_tc), 32'd0);
      tick(); check("p1_q", w_q, 32'(9 + i));
    end

    // Wrap at Max
    w_en = 1'b0; w_load = 1'b1; w_din = 32'd63;
    tick(); check("p2_load63", w_q, 32'd63);
    w_load = 1'b0; w_en = 1'b1; w_up = 1'b1;
    #1; check("p2_tc_63", 32'(w_tc), 32'd0);
    tick(); check("p2_q64", w_q, 32'd64);
    #1; check("p2_tc_64", 32'(w_tc), 32'd1);
    check("p2_ovf_before", 32'(w_ovf), 32'd0);
    tick(); check("p2_wrap_q", w_q, 32'd8);
    check("p2_ovf_after", 32'(w_ovf), Sticky);
    #1; check("p2_tc_8up", 32'(w_tc), 32'd0);

    // Load clamp and load priority over enable
    w_en = 1'b0; w_load = 1'b1; w_din = 32'd3;
    tick(); check("p4_clamp_lo", w_q, 32'd8);
    w_din = 32'd200;
    tick(); check("p4_clamp_hi", w_q, 32'd64);
    w_en = 1'b1; w_up = 1'b1; w_din = 32'd20;
    #1; check("p4_tc_load", 32'(w_tc), 32'd0);
    tick(); check("p4_load_wins", w_q, 32'd20);
    w_load = 1'b0; w_en = 1'b0;
    tick(); check("p4_hold", w_q, 32'd20);
    w_en = 1'b1; w_up = 1'b0;
    tick(); check("p4_down", w_q, 32'd19);
    w_up = 1'b1;
    tick(); check("p4_dir_change", w_q, 32'd20);

    // Reset beats load; clears the sticky flag
    reset = 1'b1; w_load = 1'b1; w_din = 32'd30;
    tick(); check("p5_rst_q", w_q, 32'd8);
    check("p5_rst_ovf", 32'(w_ovf), 32'd0);
    w_load = 1'b0; w_en = 1'b1; w_up = 1'b0;
    #1; check("p5_tc_in_rst", 32'(w_tc), 32'd0);
    tick(); check("p5_rst_hold", w_q, 32'd8);
    reset = 1'b0;
    #1; check("p5_tc_min_down", 32'(w_tc), 32'd1);
    tick(); check("p5_wrap_down", w_q, 32'd64);
    check("p5_ovf_set", 32'(w_ovf), Sticky);

    // Sticky clear, and set winning over clear
    w_en = 1'b0; w_clear = 1'b1;
    tick(); check("p6_clear", 32'(w_ovf), 32'd0);
    w_clear = 1'b0; w_en = 1'b1; w_up = 1'b1;
    tick(); check("p6_wrap1_q", w_q, 32'd8);
    check("p6_wrap1_ovf", 32'(w_ovf), Sticky);
    w_up = 1'b0; w_clear = 1'b1;
    #1; check("p6_tc_wrap2", 32'(w_tc), 32'd1);
    tick(); check("p6_wrap2_q", w_q, 32'd64);
    check("p6_set_wins", 32'(w_ovf), Sticky);
    w_en = 1'b0;
    tick(); check("p6_clear_alone", 32'(w_ovf), 32'd0);
    check("p6_hold_q", w_q, 32'd64);
    w_clear = 1'b0;

    // Saturating instance
    s_load = 1'b1; s_din = 32'd9;
    tick(); check("p3_load9", s_q, 32'd9);
    s_load = 1'b0; s_en = 1'b1; s_up = 1'b0;
    #1; check("p3_tc_9", 32'(s_tc), 32'd0);
    tick(); check("p3_q8a", s_q, 32'd8);
    #1; check("p3_tc_8a", 32'(s_tc), 32'd1);
    tick(); check("p3_q8b", s_q, 32'd8);
    #1; check("p3_tc_8b", 32'(s_tc), 32'd1);
    tick(); check("p3_q8c", s_q, 32'd8);
    check("p3_ovf", 32'(s_ovf), Sticky);
    s_load = 1'b1; s_din = 32'd100;
    tick(); check("p3_clamp_hi", s_q, 32'd64);
    s_load = 1'b0; s_up = 1'b1;
    #1; check("p3_tc_max", 32'(s_tc), 32'd1);
    tick(); check("p3_sat_max", s_q, 32'd64);
    s_en = 1'b0; s_load = 1'b1; s_din = 32'd0;
    tick(); check("p3_clamp_lo", s_q, 32'd8);
    s_load = 1'b0;

    // Narrow full-range instance
    n_en = 1'b1; n_up = 1'b0;
    #1; check("n_tc_min", 32'(n_tc), 32'd1);
    tick(); check("n_wrap_down", 32'(n_q), 32'd15);
    n_up = 1'b1;
    #1; check("n_tc_max", 32'(n_tc), 32'd1);
    tick(); check("n_wrap_up", 32'(n_q), 32'd1);
    #1; check("n_tc_mid", 32'(n_tc), 32'd0);
    tick(); check("n_step", 32'(n_q), 32'd2);
    n_en = 1'b0; n_load = 1'b1; n_din = 4'd0;
    tick(); check("n_clamp_lo", 32'(n_q), 32'd1);
    n_din = 4'd15;
    tick(); check("n_load_max", 32'(n_q), 32'd15);
    check("n_ovf", 32'(n_ovf), Sticky);
    n_load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
